// File: rtl/fetch_redirect_unit.sv
// IF-stage PC and IF/ID register with ID-driven redirect,
// wrong-path squash, hazard stall, misalign trap and redirect counter.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flow_change_i,
  input  logic             is_jalr_i,
  input  logic [31:0]      target_addr_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_rdata_i,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_pc4_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_count_o
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]  state;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] eff_target;
  logic        run;
  logic        accept;

  assign imem_addr_o = pc;
  assign pc4         = pc + 32'd4;
  assign eff_target  = is_jalr_i ? {target_addr_i[31:1], 1'b0}
                                 : target_addr_i;
  assign run         = (state == S_RUN);
  // Stalled cycles carry unresolved ID operands, so no redirect then.
  assign accept      = flow_change_i & if_id_valid_o & ~stall_i & run;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= S_RUN;
      pc               <= RESET_PC;
      if_id_pc_o       <= 32'd0;
      if_id_pc4_o      <= 32'd4;
      if_id_instr_o    <= NOP_INSTR;
      if_id_valid_o    <= 1'b0;
      misalign_o       <= 1'b0;
      redirect_count_o <= '0;
    end else begin
      unique case (1'b1)
        !run: begin
          if_id_instr_o <= NOP_INSTR;
          if_id_valid_o <= 1'b0;
        end
        run && stall_i: begin
          pc <= pc;
        end
        accept && !eff_target[1]: begin
          pc            <= eff_target;
          if_id_pc_o    <= pc;
          if_id_pc4_o   <= pc4;
          if_id_instr_o <= NOP_INSTR;
          if_id_valid_o <= 1'b0;
          if (redirect_count_o != CNT_MAX)
            redirect_count_o <= redirect_count_o + CNT_ONE;
        end
        accept && eff_target[1]: begin
          state         <= S_HALT;
          misalign_o    <= 1'b1;
          if_id_instr_o <= NOP_INSTR;
          if_id_valid_o <= 1'b0;
        end
        default: begin
          pc            <= pc4;
          if_id_pc_o    <= pc;
          if_id_pc4_o   <= pc4;
          if_id_instr_o <= imem_rdata_i;
          if_id_valid_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: default instance plus a
// wrap/saturate instance, checked against a behavioural model.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        fc;
  logic        jalr;
  logic [31:0] tgt;

  logic [31:0] a0, p0, p40, i0, rd0;
  logic        v0, m0;
  logic [15:0] c0;
  logic [31:0] a1, p1, p41, i1, rd1;
  logic        v1, m1;
  logic [1:0]  c1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
  endfunction

  assign rd0 = mem(a0);
  assign rd1 = mem(a1);

  fetch_redirect_unit u0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .flow_change_i(fc), .is_jalr_i(jalr),
    .target_addr_i(tgt), .imem_addr_o(a0),
    .imem_rdata_i(rd0), .if_id_pc_o(p0),
    .if_id_pc4_o(p40), .if_id_instr_o(i0),
    .if_id_valid_o(v0), .misalign_o(m0),
    .redirect_count_o(c0)
  );

  fetch_redirect_unit #(
    .RESET_PC(32'hFFFF_FFFC), .CNT_W(2)
  ) u1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .flow_change_i(fc), .is_jalr_i(jalr),
    .target_addr_i(tgt), .imem_addr_o(a1),
    .imem_rdata_i(rd1), .if_id_pc_o(p1),
    .if_id_pc4_o(p41), .if_id_instr_o(i1),
    .if_id_valid_o(v1), .misalign_o(m1),
    .redirect_count_o(c1)
  );

  // model state, index 0 = u0, 1 = u1
  logic [31:0] m_pc [2];
  logic [31:0] m_ipc [2];
  logic [31:0] m_ins [2];
  logic        m_val [2];
  logic        m_halt [2];
  int          m_cnt [2];
  bit          m_ok = 0;

  const logic [31:0] rpc [2] = '{32'h0, 32'hFFFF_FFFC};
  const int          cmax [2] = '{65535, 3};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] t;
      t = jalr ? (tgt & ~32'd1) : tgt;
      if (rst) begin
        m_pc[k] = rpc[k]; m_ipc[k] = 0;
        m_ins[k] = 32'h13; m_val[k] = 0;
        m_halt[k] = 0; m_cnt[k] = 0;
      end else if (m_halt[k]) begin
        m_ins[k] = 32'h13; m_val[k] = 0;
      end else if (stall) begin
      end else if (fc && m_val[k]) begin
        m_ins[k] = 32'h13; m_val[k] = 0;
        if (t % 4 != 0) m_halt[k] = 1;
        else begin
          m_pc[k] = t;
          if (m_cnt[k] < cmax[k]) m_cnt[k]++;
        end
      end else begin
        m_ipc[k] = m_pc[k];
        m_ins[k] = mem(m_pc[k]);
        m_val[k] = 1;
        m_pc[k] = m_pc[k] + 4;
      end
    end
    if (rst) m_ok = 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("u0.addr", a0, m_pc[0]);
      chk("u0.valid", 32'(v0), 32'(m_val[0]));
      chk("u0.instr", i0, m_ins[0]);
      chk("u0.mis", 32'(m0), 32'(m_halt[0]));
      chk("u0.cnt", 32'(c0), m_cnt[0]);
      if (m_val[0]) begin
        chk("u0.pc", p0, m_ipc[0]);
        chk("u0.pc4", p40, m_ipc[0] + 4);
      end
      chk("u1.addr", a1, m_pc[1]);
      chk("u1.valid", 32'(v1), 32'(m_val[1]));
      chk("u1.instr", i1, m_ins[1]);
      chk("u1.mis", 32'(m1), 32'(m_halt[1]));
      chk("u1.cnt", 32'(c1), m_cnt[1]);
      if (m_val[1]) begin
        chk("u1.pc", p1, m_ipc[1]);
        chk("u1.pc4", p41, m_ipc[1] + 4);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1; stall = 0; fc = 0; jalr = 0; tgt = 0;
    cyc(2);
    chk("rst.addr", a0, 32'h0);
    chk("rst.valid", 32'(v0), 32'h0);
    chk("rst.instr", i0, 32'h13);
    rst = 0;
    cyc(1);
    chk("rel.pc", p0, 32'h0);
    chk("rel.valid", 32'(v0), 32'h1);
    chk("rel.addr", a0, 32'h4);
    chk("wrap.addr", a1, 32'h0);
    chk("wrap.pc", p1, 32'hFFFF_FFFC);
    cyc(1);
    stall = 1;
    cyc(3);
    chk("stall.addr", a0, 32'h8);
    chk("stall.pc", p0, 32'h4);
    stall = 0;
    cyc(1);
    chk("unst.addr", a0, 32'hC);
    chk("unst.pc", p0, 32'h8);
    fc = 1; tgt = 32'h40;
    cyc(1);
    chk("br.addr", a0, 32'h40);
    chk("br.valid", 32'(v0), 32'h0);
    chk("br.instr", i0, 32'h13);
    chk("br.cnt", 32'(c0), 32'd1);
    fc = 0;
    cyc(1);
    chk("br.pc", p0, 32'h40);
    stall = 1; fc = 1; tgt = 32'h80;
    cyc(1);
    chk("col.addr", a0, 32'h44);
    chk("col.cnt", 32'(c0), 32'd1);
    stall = 0;
    cyc(1);
    chk("col2.addr", a0, 32'h80);
    chk("col2.cnt", 32'(c0), 32'd2);
    cyc(1);
    chk("bub.addr", a0, 32'h84);
    chk("bub.cnt", 32'(c0), 32'd2);
    jalr = 1; tgt = 32'h101;
    cyc(1);
    chk("jalr.addr", a0, 32'h100);
    chk("jalr.cnt", 32'(c0), 32'd3);
    fc = 0;
    cyc(1);
    fc = 1; tgt = 32'h102;
    cyc(1);
    chk("mis.flag", 32'(m0), 32'h1);
    fc = 0; jalr = 0;
    for (int i = 0; i < 10; i++) begin
      stall = i[0]; fc = i[1]; tgt = 32'h200;
      cyc(1);
      chk("halt.addr", a0, 32'h104);
      chk("halt.valid", 32'(v0), 32'h0);
    end
    stall = 0; fc = 0; rst = 1;
    cyc(1);
    chk("rst2.mis", 32'(m0), 32'h0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      fc = 0;
      cyc(1);
      fc = 1; tgt = 32'h1000 + 32'(i * 16);
      cyc(1);
    end
    fc = 0;
    cyc(1);
    chk("sat.cnt0", 32'(c0), 32'd5);
    chk("sat.cnt1", 32'(c1), 32'd3);
    cyc(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
